// File: rtl/pc_round_seq.sv
// ASCON round sequencer: holds the 320-bit state, owns the round counter and adds the round
// constant before handing the state to an external substitution/diffusion path.
// Optional abort input is enabled by defining PC_ABORT_EN.
module pc_round_seq #(
    parameter int unsigned ROUNDS_A   = 12,
    parameter int unsigned ROUNDS_B   = 6,
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned CONST_WORD = 2
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [5*WORD_W-1:0]   state_i,
    input  logic [5*WORD_W-1:0]   fb_state_i,
    output logic [5*WORD_W-1:0]   state_o,
    output logic [3:0]            round_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef PC_ABORT_EN
    ,
    input  logic                  abort_i
`endif
);

    if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
        $error("ROUNDS_A must be in 1..12");
    end
    if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
        $error("ROUNDS_B must be in 1..12");
    end
    if (CONST_WORD > 4) begin : g_bad_const_word
        $error("CONST_WORD must be in 0..4");
    end
    if (WORD_W < 8) begin : g_bad_word_w
        $error("WORD_W must be at least 8");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fsm_e;

    // The last round is always 11, so shorter permutations simply start later.
    localparam logic [3:0] StartRoundA = 4'(12 - ROUNDS_A);
    localparam logic [3:0] StartRoundB = 4'(12 - ROUNDS_B);
    localparam int unsigned ConstLsb   = CONST_WORD * WORD_W;

    fsm_e                r_fsm_q;
    fsm_e                w_fsm_d;
    logic [5*WORD_W-1:0] r_state_q;
    logic [5*WORD_W-1:0] w_state_d;
    logic [3:0]          r_round_q;
    logic [3:0]          w_round_d;
    logic [7:0]          w_rc;
    logic [WORD_W-1:0]   w_const;

    assign w_rc    = {4'hF - r_round_q, r_round_q};
    assign w_const = WORD_W'(w_rc);

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            r_fsm_q   <= StIdle;
            r_state_q <= '0;
            r_round_q <= '0;
        end else begin
            r_fsm_q   <= w_fsm_d;
            r_state_q <= w_state_d;
            r_round_q <= w_round_d;
        end
    end

    always_comb begin
        w_fsm_d   = r_fsm_q;
        w_state_d = r_state_q;
        w_round_d = r_round_q;
        unique case (r_fsm_q)
            StIdle: begin
                if (start_i) begin
                    w_state_d = state_i;
                    w_round_d = mode_i ? StartRoundB : StartRoundA;
                    w_fsm_d   = StRun;
                end
            end
            StRun: begin
                w_state_d = fb_state_i;
                if (r_round_q == 4'd11) begin
                    w_fsm_d = StDone;
                end else begin
                    w_round_d = r_round_q + 4'd1;
                end
`ifdef PC_ABORT_EN
                // Abandon the job without loading the in-flight feedback.
                if (abort_i) begin
                    w_state_d = r_state_q;
                    w_round_d = r_round_q;
                    w_fsm_d   = StIdle;
                end
`endif
            end
            StDone: begin
                w_fsm_d = StIdle;
            end
            default: begin
                w_fsm_d = StIdle;
            end
        endcase
    end

    always_comb begin
        state_o = r_state_q;
        if (r_fsm_q == StRun) begin
            state_o[ConstLsb +: WORD_W] = r_state_q[ConstLsb +: WORD_W] ^ w_const;
        end
    end

    assign round_o = r_round_q;
    assign valid_o = (r_fsm_q == StRun);
    assign busy_o  = (r_fsm_q == StRun) || (r_fsm_q == StDone);
    assign done_o  = (r_fsm_q == StDone);

endmodule

// File: tb/tb_pc_round_seq.sv
// Directed self-checking bench for pc_round_seq with default parameters.
// Exercises the abort path too when PC_ABORT_EN is defined.
module tb_pc_round_seq;

    logic         clk;
    logic         resetb;
    logic         start;
    logic         mode;
    logic [319:0] state_in;
    logic [319:0] fb_drv;
    logic [319:0] fb;
    logic         loop;
    logic [319:0] state_o;
    logic [3:0]   round_o;
    logic         valid_o;
    logic         busy_o;
    logic         done_o;
`ifdef PC_ABORT_EN
    logic         abort;
`endif

    int n_vec = 0;
    int n_err = 0;

    pc_round_seq dut (
        .clock_i    (clk),
        .resetb_i   (resetb),
        .start_i    (start),
        .mode_i     (mode),
        .state_i    (state_in),
        .fb_state_i (fb),
        .state_o    (state_o),
        .round_o    (round_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef PC_ABORT_EN
        ,
        .abort_i    (abort)
`endif
    );

    assign fb = loop ? state_o : fb_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rc(input int r);
        logic [3:0] n;
        n = 4'(r);
        return {4'hF - n, n};
    endfunction

    function automatic logic [319:0] with_c(input logic [319:0] v, input int r);
        logic [319:0] m;
        m = '0;
        m[135:128] = rc(r);
        return v ^ m;
    endfunction

    function automatic logic [319:0] fval(input int r);
        return {5{56'hA5A5_5A5A_0F0F_F0, 8'(r)}};
    endfunction

    // Feedback tied to state_o, state_i = 0: word 2 accumulates the constants.
    task automatic run_job(input logic m, input int n, input logic [7:0] exp_first,
                           input logic [7:0] exp_final);
        logic [7:0] acc;
        int         r;
        acc      = '0;
        loop     = 1'b1;
        state_in = '0;
        mode     = m;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("first_w2", 320'(state_o[191:128]), 320'(exp_first));
        for (int i = 0; i < n; i++) begin
            r = 12 - n + i;
            chk("run_round", 320'(round_o), 320'(r));
            chk("run_flags", 320'({valid_o, busy_o, done_o}), 320'(3'b110));
            chk("run_w2", 320'(state_o[191:128]), 320'(acc ^ rc(r)));
            acc = acc ^ rc(r);
            step();
        end
        chk("done_flags", 320'({valid_o, busy_o, done_o}), 320'(3'b011));
        chk("done_round", 320'(round_o), 320'(11));
        chk("done_state", state_o, 320'(exp_final) << 128);
        step();
        chk("idle_flags", 320'({valid_o, busy_o, done_o}), 320'(3'b000));
        chk("idle_hold", state_o, 320'(exp_final) << 128);
    endtask

    initial begin
        logic [319:0] s0;
        logic [15:0]  v_seq;
        logic [15:0]  b_seq;
        logic [15:0]  d_seq;

        resetb   = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        state_in = '0;
        fb_drv   = '0;
        loop     = 1'b1;
`ifdef PC_ABORT_EN
        abort    = 1'b0;
`endif
        step();
        step();
        resetb = 1'b1;
        chk("reset_state", state_o, 320'(0));
        chk("reset_ctl", 320'({round_o, valid_o, busy_o, done_o}), 320'(0));

        run_job(1'b0, 12, 8'hF0, 8'h00);
        run_job(1'b1, 6, 8'h96, 8'h11);

        // Reset at round 8 of p^a.
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("pre_reset_round", 320'(round_o), 320'(8));
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        chk("midreset_state", state_o, 320'(0));
        chk("midreset_ctl", 320'({round_o, valid_o, busy_o, done_o}), 320'(0));
        step();
        chk("midreset_after", 320'({valid_o, busy_o, done_o}), 320'(3'b000));

        // Bench-driven feedback, distinct per round.
        s0       = {5{64'h0123_4567_89AB_CDEF}};
        loop     = 1'b0;
        state_in = s0;
        mode     = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("fb_first", state_o, with_c(s0, 6));
        for (int r = 6; r < 12; r++) begin
            fb_drv = fval(r);
            step();
            if (r < 11) chk("fb_capture", state_o, with_c(fval(r), r + 1));
        end
        chk("fb_done", 320'(done_o), 320'(1));
        chk("fb_final", state_o, fval(11));
        step();
        loop = 1'b1;

        // start held high across back-to-back p^b jobs.
        state_in = '0;
        mode     = 1'b1;
        start    = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            v_seq[i] = valid_o;
            b_seq[i] = busy_o;
            d_seq[i] = done_o;
            if (i == 13) start = 1'b0;
            step();
        end
        chk("b2b_valid", 320'(v_seq), 320'(16'h3F3F));
        chk("b2b_busy", 320'(b_seq), 320'(16'h7F7F));
        chk("b2b_done", 320'(d_seq), 320'(16'h4040));

`ifdef PC_ABORT_EN
        // Abort at round 3 of p^a; register keeps the value loaded at round 3.
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("abort_round", 320'(round_o), 320'(3));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_flags", 320'({valid_o, busy_o, done_o}), 320'(3'b000));
        chk("abort_state", state_o, 320'(rc(0) ^ rc(1) ^ rc(2)) << 128);
        step();
        chk("abort_nodone", 320'({valid_o, busy_o, done_o}), 320'(3'b000));
        run_job(1'b1, 6, 8'h96, 8'h11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
